// File: rtl/adder_tree_sched_pkg.sv
// Shared definitions for the adder-tree scheduler: FSM encoding, operand geometry, tag format.
package adder_tree_sched_pkg;

  localparam int OP_W         = 8;
  localparam int OP_N         = 8;
  localparam int VEC_W        = OP_W * OP_N;
  localparam int TREE_LAT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

endpackage

// File: rtl/adder_tree_sched_rr_arb2.sv
// Two-input round-robin arbiter; the pointer remembers who was granted last and moves only on a grant.
module rr_arb2
  import adder_tree_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio1;  // set when requester 1 has priority on a tie

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && req[1]) gnt = prio1 ? 2'b10 : 2'b01;
      else                  gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         prio1 <= 1'b0;
    else if (gnt[0]) prio1 <= 1'b1;
    else if (gnt[1]) prio1 <= 1'b0;
  end

endmodule

// File: rtl/adder_tree_sched.sv
// Schedules two requesters onto one shared adder tree and routes results back by owner tag.
// Optional grant counters are built when ADDER_TREE_SCHED_PERF_EN is defined.
//
// state | meaning
// IDLE  | nothing issued recently, grants allowed
// RUN   | issuing and/or tags in flight, grants allowed
// DRAIN | flush requested, no grants, waiting for tag pipe to empty
// DONE  | drain complete, flush_done pulses for this one cycle
module adder_tree_sched
  import adder_tree_sched_pkg::*;
#(
  parameter int TREE_LAT = TREE_LAT_DEF,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [VEC_W-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [VEC_W-1:0] req1_data,
  output logic             req1_ready,
  output logic [VEC_W-1:0] tree_in,
  input  logic [OP_W-1:0]  tree_sum,
  output logic [OP_W-1:0]  res_sum,
  output logic             res0_valid,
  output logic             res1_valid,
  input  logic             flush,
  output logic             flush_done,
  output logic             busy
`ifdef ADDER_TREE_SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_grant0,
  output logic [CNT_W-1:0] perf_grant1
`endif
);

  if (TREE_LAT < 1 || TREE_LAT > 8 || CNT_W < 1) begin : g_param_chk
    $error("adder_tree_sched: TREE_LAT must be 1..8 and CNT_W at least 1");
  end

  state_t                state, state_nxt;
  tag_t [TREE_LAT-1:0]   tags;
  tag_t                  tag_out;
  logic                  pipe_busy;
  logic                  grant_en;
  logic [1:0]            gnt;
  logic                  gnt_any;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (grant_en),
    .req ({req1_valid, req0_valid}),
    .gnt (gnt)
  );

  assign gnt_any    = |gnt;
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign tree_in    = gnt[0] ? req0_data : (gnt[1] ? req1_data : '0);

  // tags[i] describes the operand vector issued i+1 cycles ago
  always_ff @(posedge clk) begin
    if (rst) begin
      tags <= '0;
    end else begin
      tags[0] <= tag_t'{valid: gnt_any, owner: gnt[1]};
      for (int i = 1; i < TREE_LAT; i++) tags[i] <= tags[i-1];
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < TREE_LAT; i++) pipe_busy = pipe_busy | tags[i].valid;
  end

  assign tag_out = tags[TREE_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      res_sum    <= '0;
      res0_valid <= 1'b0;
      res1_valid <= 1'b0;
    end else begin
      res0_valid <= tag_out.valid && !tag_out.owner;
      res1_valid <= tag_out.valid &&  tag_out.owner;
      if (tag_out.valid) res_sum <= tree_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // flush wins over a grant in the same cycle because grant_en drops with flush
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (flush) state_nxt = ST_DRAIN;
                else if (gnt_any) state_nxt = ST_RUN;
      ST_RUN:   if (flush) state_nxt = ST_DRAIN;
                else if (!gnt_any && !pipe_busy) state_nxt = ST_IDLE;
      ST_DRAIN: if (!pipe_busy) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_en   = ((state == ST_IDLE) || (state == ST_RUN)) && !flush;
    flush_done = (state == ST_DONE);
    busy       = (state != ST_IDLE) || pipe_busy;
  end

`ifdef ADDER_TREE_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
    end else begin
      if (gnt[0] && (perf_grant0 != '1)) perf_grant0 <= perf_grant0 + CNT_W'(1);
      if (gnt[1] && (perf_grant1 != '1)) perf_grant1 <= perf_grant1 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/adder_tree_sched.md
ADDER_TREE_SCHED -- requirements
Module: adder_tree_sched

Interface
REQ-001: Parameter TREE_LAT, default 4, SHALL set the cycles from operand issue to valid tree_sum; legal range 1..8.
REQ-002: Parameter CNT_W, default 16, SHALL set the width of each performance counter.
REQ-003: clk  in  1  single clock; all logic on its rising edge.
REQ-004: rst  in  1  reset, synchronous and active-high.
REQ-005: req0_valid  in  1  requester 0 has an operand vector.
REQ-006: req0_data  in  64  eight packed 8-bit operands; operand k in bits [8k+7:8k].
REQ-007: req0_ready  out  1  requester 0 vector accepted this cycle.
REQ-008: req1_valid, req1_data, req1_ready SHALL mirror REQ-005..007 for requester 1.
REQ-009: tree_in  out  64  operand vector driven to the shared adder tree.
REQ-010: tree_sum  in  8  registered tree result, valid TREE_LAT cycles after issue.
REQ-011: res_sum  out  8  registered result, routed to the owning requester.
REQ-012: res0_valid, res1_valid  out  1 each  one-cycle result strobes; never both high.
REQ-013: flush  in  1  drain request.
REQ-014: flush_done  out  1  one-cycle pulse when the drain completes.
REQ-015: busy  out  1  high while the state is not IDLE or any tag is in flight.
REQ-016: perf_grant0, perf_grant1  out  CNT_W each  grant counters (only with ADDER_TREE_SCHED_PERF_EN).

Function
REQ-017: At most one grant per cycle; grant occurs only when the state is IDLE or RUN and the selected reqN_valid is 1.
REQ-018: reqN_ready SHALL be combinational and equal to the grant for N; the handshake completes when valid and ready are both high.
REQ-019: Round-robin: with only one request valid, that requester wins; with both valid, the requester not granted last wins; the pointer updates only on a grant.
REQ-020: tree_in SHALL be the granted reqN_data in the grant cycle, else 64'h0.
REQ-021: A TREE_LAT-deep tag shift register SHALL carry {valid, owner} per issue; on exit, res_sum <= tree_sum and resN_valid <= 1 for the owner, one register stage later (total request-to-result latency TREE_LAT+1).
REQ-022: The sum SHALL be modulo 256 (tree wrap); no carry or overflow is reported.
REQ-023: FSM states IDLE, RUN, DRAIN, DONE. IDLE->RUN on grant; RUN->IDLE when the tag pipe is empty and no grant occurs; IDLE/RUN->DRAIN on flush=1 (flush has priority over grant that cycle); DRAIN->DONE when the tag pipe is empty; DONE->IDLE unconditionally.
REQ-024: In DRAIN no grants; in-flight results SHALL still be delivered.
REQ-025: flush_done=1 only in DONE; flush held high re-enters DRAIN from IDLE on the next cycle.
REQ-026: A grant and a result exit in the same cycle SHALL both be honoured.

Reset
REQ-027: On rst: state IDLE, all tags invalid, RR pointer favours requester 0, res_sum=0, res0_valid=res1_valid=0, flush_done=0, counters=0.
REQ-028: Reset mid-operation SHALL discard all in-flight tags; no result strobe SHALL appear for issues made before reset.

Configuration
REQ-029: Macro ADDER_TREE_SCHED_PERF_EN defined: perf_grant0/1 present, incrementing per grant and saturating at all-ones. Not defined: ports and counters absent, with no other behavioural change.

Structure
REQ-030: Shared package SHALL hold the FSM state encoding, the operand width (8), the operand count (8), and the TREE_LAT default.
REQ-031: Sub-module rr_arb2 (two-input round-robin arbiter with pointer register) SHALL be instantiated once; the tag pipeline and FSM stay in the top.

Verification
REQ-032: req0 operands all 8'h01, single request -> req0_ready in cycle 0; res0_valid with res_sum=8'h08 at cycle 5 (TREE_LAT=4).
REQ-033: req1 operands all 8'hFF -> res1_valid with res_sum=8'hF8; res0_valid stays 0.
REQ-034: Both valid for 6 cycles -> grants 0,1,0,1,0,1; results return in the same order, each with its owner strobe.
REQ-035: Three issues, then flush -> no ready while DRAIN; all three results delivered; flush_done pulses one cycle after the last tag exits; then IDLE.
REQ-036: rst asserted 2 cycles after a grant -> no res strobe; busy=0 the cycle after reset.
REQ-037: With ADDER_TREE_SCHED_PERF_EN, 5 grants to req0 and 3 to req1 -> perf_grant0=5, perf_grant1=3; forcing a counter to all-ones plus one grant -> it holds all-ones.
